rq_phin_streamer: RTL

- Downstream stage of the Rq polynomial multiplier (NTRU-HRSS, N=701, q=2^13).
- On a start pulse, captures the multiplier's full product vector e, then streams it out one coefficient per handshake beat.
- Each coefficient is reduced modulo Phi_N: out_k = (e_k - e_{N-1}) mod 2^13.
- Feeds serial consumers (packer / hash input) through a valid/ready interface.

---
 rtl/rq_phin_streamer_pkg.sv | 20 ++
 rtl/rq_phin_streamer_if.sv | 27 ++
 rtl/rq_coef_sub.sv | 12 +
 rtl/rq_phin_streamer.sv | 88 ++++++++
 4 files changed

// File: rtl/rq_phin_streamer_pkg.sv
// rtl/rq_phin_streamer_pkg.sv - shared Rq constants, coefficient/polynomial types and streamer FSM states
package rq_pkg;

   localparam int NUM_N              = 701;
   localparam int NUM_WIDTH_LENGTH_H = 13;
   localparam int IDX_W              = 10;

   typedef logic [NUM_WIDTH_LENGTH_H-1:0]       coef_t;
   typedef logic [NUM_N*NUM_WIDTH_LENGTH_H-1:0] poly_t;
   typedef logic [IDX_W-1:0]                    idx_t;

   localparam idx_t K_LAST = IDX_W'(NUM_N - 1);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } state_t;

endpackage

// File: rtl/rq_phin_streamer_if.sv
// rtl/rq_phin_streamer_if.sv - reduced-coefficient output stream (valid/ready with index and last marker)
interface rq_phin_streamer_if;
   import rq_pkg::*;

   logic  out_valid;
   logic  out_ready;
   coef_t out_coef;
   idx_t  out_idx;
   logic  out_last;

   modport master (
      output out_valid,
      output out_coef,
      output out_idx,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_coef,
      input  out_idx,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/rq_coef_sub.sv
// rtl/rq_coef_sub.sv - combinational mod-2^H coefficient subtractor (a - b), wraps naturally at H bits
module rq_coef_sub
   import rq_pkg::*;
(
   input  coef_t a,
   input  coef_t b,
   output coef_t d
);

   assign d = a - b;

endmodule

// File: rtl/rq_phin_streamer.sv
// rtl/rq_phin_streamer.sv - captures product vector e and streams (e_k - e_{N-1}) mod 2^H, one beat per handshake
// Optional RQ_PHIN_CHECKSUM_EN adds chk_sum, the running mod-2^H sum of transferred coefficients.
module rq_phin_streamer
   import rq_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  start,
   input  poly_t e_in,
   output logic  busy,
   output logic  done,
`ifdef RQ_PHIN_CHECKSUM_EN
   output coef_t chk_sum,
`endif
   rq_phin_streamer_if.master out
);

   state_t state_q, state_d;
   poly_t  buf_q;
   coef_t  e_top_q;
   idx_t   k_q;
   coef_t  diff;
   logic   streaming;
   logic   xfer;
   logic   capture;

   assign streaming = (state_q == STREAM);
   assign xfer      = streaming & out.out_ready;
   assign capture   = (state_q == IDLE) & start;

   rq_coef_sub u_sub (
      .a (buf_q[NUM_WIDTH_LENGTH_H-1:0]),
      .b (e_top_q),
      .d (diff)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = STREAM;
         STREAM:  if (xfer && k_q == K_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Buffer shifts down so the current coefficient always sits in the low H bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q   <= '0;
         e_top_q <= '0;
         k_q     <= '0;
      end else if (capture) begin
         buf_q   <= e_in;
         e_top_q <= e_in[(NUM_N-1)*NUM_WIDTH_LENGTH_H +: NUM_WIDTH_LENGTH_H];
         k_q     <= '0;
      end else if (xfer) begin
         buf_q <= buf_q >> NUM_WIDTH_LENGTH_H;
         if (k_q != K_LAST) k_q <= k_q + IDX_W'(1);
      end
   end

   // Outputs are gated to zero outside STREAM; the drained buffer would otherwise show -e_top.
   assign out.out_valid = streaming;
   assign out.out_coef  = streaming ? diff : '0;
   assign out.out_idx   = streaming ? k_q : '0;
   assign out.out_last  = streaming && (k_q == K_LAST);
   assign busy          = streaming;
   assign done          = (state_q == DONE);

`ifdef RQ_PHIN_CHECKSUM_EN
   coef_t chk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       chk_q <= '0;
      else if (capture) chk_q <= '0;
      else if (xfer)    chk_q <= chk_q + diff;
   end

   assign chk_sum = chk_q;
`endif

endmodule
